// File: rtl/mlt_ctrl_pkg.sv
// Shared definitions for the shift-free multiplier controller: state encoding,
// strobe bundle and default datapath/latency sizing.
package mlt_ctrl_pkg;

  localparam int MLT_WIDTH    = 16;
  localparam int MLT_ZERO_LAT = 2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDA  = 3'd1,
    S_LDB  = 3'd2,
    S_WAIT = 3'd3,
    S_ADD  = 3'd4,
    S_DONE = 3'd5
  } mlt_state_e;

  typedef struct packed {
    logic ld_a;
    logic ld_b;
    logic cr_p;
    logic ld_p;
    logic dc_b;
  } mlt_strb_t;

  // Strobe groups are a pure function of the state, so only one group can be live.
  function automatic mlt_strb_t strb_decode(input mlt_state_e s);
    mlt_strb_t r;
    r = '0;
    case (s)
      S_LDA: r.ld_a = 1'b1;
      S_LDB: begin
        r.ld_b = 1'b1;
        r.cr_p = 1'b1;
      end
      S_ADD: begin
        r.ld_p = 1'b1;
        r.dc_b = 1'b1;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mlt_ctrl_lat_cnt.sv
// Loadable down-counter with terminal flag; times the wait for the datapath
// zero flag to settle after B changes.
module lat_cnt #(
  parameter int CW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          dec_i,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Load has priority; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/mlt_ctrl.sv
// Repeated-addition multiplier controller driving an external A/B/P datapath.
// Optional iteration limit enabled by defining MLT_CTRL_TIMEOUT_EN.
module mlt_ctrl
  import mlt_ctrl_pkg::*;
#(
  parameter int          WIDTH    = MLT_WIDTH,
  parameter int          ZERO_LAT = MLT_ZERO_LAT,
  parameter int unsigned MAX_ITER = 32'h0000_FFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             zero,
  input  logic [WIDTH-1:0] result_in,
  output logic             ld_a,
  output logic             ld_b,
  output logic             ld_p,
  output logic             cr_p,
  output logic             dc_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic [WIDTH-1:0] iter_cnt,
  output logic             timeout
);

  localparam int               CW         = (ZERO_LAT > 1) ? $clog2(ZERO_LAT) : 1;
  localparam logic [CW-1:0]    LAT_LOAD   = CW'(ZERO_LAT - 1);
  localparam logic [WIDTH-1:0] MAX_ITER_W = WIDTH'(MAX_ITER);

  mlt_state_e       state_q, state_d;
  mlt_strb_t        strb_q;
  logic             done_q, busy_q;
  logic [WIDTH-1:0] product_q, product_d;
  logic [WIDTH-1:0] iter_q, iter_d;
  logic             lat_load_s, lat_dec_s, lat_tc_s;
  logic             load_prod_s, to_hit_s;

`ifdef MLT_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
  logic timeout_q;

  // Timeout flag: raised on the limit-forced exit, dropped on entry to LDA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else if (state_d == S_LDA) begin
      timeout_q <= 1'b0;
    end else if ((state_q == S_WAIT) && lat_tc_s && !zero && to_hit_s) begin
      timeout_q <= 1'b1;
    end else begin
      timeout_q <= timeout_q;
    end
  end

  assign timeout = timeout_q;
`else
  localparam bit TO_EN = 1'b0;
  assign timeout = 1'b0;
`endif

  assign to_hit_s   = TO_EN && (iter_q == MAX_ITER_W);
  assign lat_load_s = (state_d == S_WAIT) && (state_q != S_WAIT);
  assign lat_dec_s  = (state_q == S_WAIT);

  lat_cnt #(.CW(CW)) u_lat_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (lat_load_s),
    .load_val_i (LAT_LOAD),
    .dec_i      (lat_dec_s),
    .tc_o       (lat_tc_s)
  );

  // Next-state logic; zero is only trusted on the final WAIT cycle.
  always_comb begin
    state_d     = state_q;
    load_prod_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LDA;
        else       state_d = S_IDLE;
      end
      S_LDA:  state_d = S_LDB;
      S_LDB:  state_d = S_WAIT;
      S_WAIT: begin
        if (!lat_tc_s) begin
          state_d = S_WAIT;
        end else if (zero || to_hit_s) begin
          state_d     = S_DONE;
          load_prod_s = 1'b1;
        end else begin
          state_d = S_ADD;
        end
      end
      S_ADD:  state_d = S_WAIT;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Result and iteration bookkeeping.
  always_comb begin
    product_d = product_q;
    iter_d    = iter_q;
    if (state_q == S_LDA) begin
      product_d = '0;
    end else if (load_prod_s) begin
      product_d = result_in;
    end else begin
      product_d = product_q;
    end
    if (state_q == S_LDB) begin
      iter_d = '0;
    end else if (state_q == S_ADD) begin
      iter_d = iter_q + WIDTH'(1'b1);
    end else begin
      iter_d = iter_q;
    end
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      strb_q    <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      product_q <= '0;
      iter_q    <= '0;
    end else begin
      state_q   <= state_d;
      strb_q    <= strb_decode(state_d);
      done_q    <= (state_d == S_DONE);
      busy_q    <= (state_d != S_IDLE);
      product_q <= product_d;
      iter_q    <= iter_d;
    end
  end

  assign ld_a     = strb_q.ld_a;
  assign ld_b     = strb_q.ld_b;
  assign cr_p     = strb_q.cr_p;
  assign ld_p     = strb_q.ld_p;
  assign dc_b     = strb_q.dc_b;
  assign busy     = busy_q;
  assign done     = done_q;
  assign product  = product_q;
  assign iter_cnt = iter_q;

endmodule
